// File: rtl/flash_image_loader.sv
// flash_image_loader: boot-time SPI master that copies one image from SPI
// flash into the emulation SRAM before the CPU is released.
//
// Ports:
//   clk, reset        system clock, async active-high reset
//   configuration     image select, sampled once after reset release
//   spi_miso          flash data in
//   spi_clk/out/cs    SPI mode 0 master outputs (cs active low)
//   ram_address/datain/cs/we  SRAM write port, one strobe per byte
//   read_complete     image loaded, held until reset
module flash_image_loader #(
  parameter int          CONFIG_BITS = 5,
  parameter logic [23:0] FLASH_BASE  = 24'h100000,
  parameter int          IMAGE_BYTES = 65536,
  parameter int          SPI_DIV     = 2,
  parameter int          WAKE_CYCLES = 200
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [CONFIG_BITS-1:0] configuration,
  input  logic                   spi_miso,
  output logic                   spi_clk,
  output logic                   spi_out,
  output logic                   spi_cs,
  output logic [15:0]            ram_address,
  output logic [7:0]             ram_datain,
  output logic                   ram_cs,
  output logic                   ram_we,
  output logic                   read_complete
);

  typedef enum logic [2:0] {
    IDLE, WAKE, WAKE_WAIT, CMD, DATA, DONE
  } state_t;

  state_t                 state;
  logic [7:0]             div_cnt;
  logic [5:0]             bit_cnt;
  logic [31:0]            shreg;
  logic [7:0]             rx;
  logic [16:0]            byte_cnt;
  logic [15:0]            wait_cnt;
  logic [CONFIG_BITS-1:0] cfg_q;
  logic [23:0]            cfg_ext;
  logic [23:0]            cmd_addr;
  logic                   tick;

  // Half-period boundary of the SPI clock.
  assign tick = (div_cnt == 8'(SPI_DIV - 1));

  always_comb begin
    cfg_ext = '0;
    cfg_ext[16 +: CONFIG_BITS] = cfg_q;
  end

  // 24-bit add wraps naturally.
  assign cmd_addr = FLASH_BASE + cfg_ext;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      rx            <= '0;
      byte_cnt      <= '0;
      wait_cnt      <= '0;
      cfg_q         <= '0;
      spi_clk       <= 1'b0;
      spi_out       <= 1'b0;
      spi_cs        <= 1'b1;
      ram_address   <= '0;
      ram_datain    <= '0;
      ram_cs        <= 1'b0;
      ram_we        <= 1'b0;
      read_complete <= 1'b0;
    end else begin
      ram_cs <= 1'b0;
      ram_we <= 1'b0;
      unique case (state)
        IDLE: begin
          cfg_q   <= configuration;
          state   <= WAKE;
          spi_cs  <= 1'b0;
          shreg   <= {8'hAB, 24'h0};
          spi_out <= 1'b1;
          spi_clk <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
        end
        WAKE: begin
          div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
          if (tick) begin
            // bit_cnt==8 is the trailing low half before cs rises.
            if (bit_cnt == 6'd8) begin
              spi_cs   <= 1'b1;
              state    <= WAKE_WAIT;
              wait_cnt <= '0;
            end else if (!spi_clk) begin
              spi_clk <= 1'b1;
            end else begin
              spi_clk <= 1'b0;
              bit_cnt <= bit_cnt + 6'd1;
              shreg   <= {shreg[30:0], 1'b0};
              spi_out <= (bit_cnt == 6'd7) ? 1'b0 : shreg[30];
            end
          end
        end
        WAKE_WAIT: begin
          if (wait_cnt == 16'(WAKE_CYCLES - 1)) begin
            state   <= CMD;
            spi_cs  <= 1'b0;
            shreg   <= {8'h03, cmd_addr};
            spi_out <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        CMD: begin
          div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
          if (tick) begin
            if (!spi_clk) begin
              spi_clk <= 1'b1;
            end else begin
              spi_clk <= 1'b0;
              shreg   <= {shreg[30:0], 1'b0};
              if (bit_cnt == 6'd31) begin
                state   <= DATA;
                bit_cnt <= '0;
                spi_out <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
                spi_out <= shreg[30];
              end
            end
          end
        end
        DATA: begin
          if (ram_we && byte_cnt == 17'(IMAGE_BYTES)) begin
            state         <= DONE;
            spi_cs        <= 1'b1;
            spi_clk       <= 1'b0;
            spi_out       <= 1'b0;
            read_complete <= 1'b1;
          end else begin
            div_cnt <= tick ? 8'd0 : div_cnt + 8'd1;
            if (tick) begin
              if (!spi_clk) begin
                spi_clk <= 1'b1;
                rx      <= {rx[6:0], spi_miso};
              end else begin
                spi_clk <= 1'b0;
                if (bit_cnt == 6'd7) begin
                  // Strobe overlaps the next byte's low half.
                  bit_cnt     <= '0;
                  ram_cs      <= 1'b1;
                  ram_we      <= 1'b1;
                  ram_datain  <= rx;
                  ram_address <= byte_cnt[15:0];
                  byte_cnt    <= byte_cnt + 17'd1;
                end else begin
                  bit_cnt <= bit_cnt + 6'd1;
                end
              end
            end
          end
        end
        DONE: begin
          spi_cs        <= 1'b1;
          spi_clk       <= 1'b0;
          spi_out       <= 1'b0;
          read_complete <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_image_loader.sv
// tb_flash_image_loader: directed bench with a small SPI flash model
// and SRAM write monitor for flash_image_loader.
module tb_flash_image_loader;

  localparam int DIV = 2;

  int checks = 0;
  int errors = 0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  configuration = '0;
  logic        miso = 1'b0;
  logic        sclk, mosi, scs, rcs, we, rc;
  logic [15:0] raddr;
  logic [7:0]  rdata;

  logic        w_reset = 1'b1;
  logic        w_sclk, w_mosi, w_scs, w_rcs, w_we, w_rc;
  logic [15:0] w_raddr;
  logic [7:0]  w_rdata;

  always #5 clk = ~clk;

  flash_image_loader #(
    .CONFIG_BITS(5), .FLASH_BASE(24'h100000), .IMAGE_BYTES(4),
    .SPI_DIV(DIV), .WAKE_CYCLES(200)
  ) u_dut (
    .clk(clk), .reset(reset), .configuration(configuration),
    .spi_miso(miso), .spi_clk(sclk), .spi_out(mosi), .spi_cs(scs),
    .ram_address(raddr), .ram_datain(rdata), .ram_cs(rcs),
    .ram_we(we), .read_complete(rc)
  );

  flash_image_loader #(
    .CONFIG_BITS(5), .FLASH_BASE(24'hFF0000), .IMAGE_BYTES(3),
    .SPI_DIV(1), .WAKE_CYCLES(20)
  ) u_wrap (
    .clk(clk), .reset(w_reset), .configuration(5'd1),
    .spi_miso(1'b1), .spi_clk(w_sclk), .spi_out(w_mosi),
    .spi_cs(w_scs), .ram_address(w_raddr), .ram_datain(w_rdata),
    .ram_cs(w_rcs), .ram_we(w_we), .read_complete(w_rc)
  );

  // Flash contents seen by the main instance.
  function automatic logic [7:0] flash_byte(input logic [23:0] a);
    logic [31:0] w;
    w = 32'hDEADBEEF;
    if (a[23:16] == 8'h13) return w[(31 - 8 * int'(a[1:0])) -: 8];
    else if (a[23:16] == 8'h12) return 8'h50 + a[7:0];
    else return a[7:0] ^ 8'h5A;
  endfunction

  // MOSI capture per chip-select window.
  int          mosi_bits = 0;
  logic [31:0] mosi_sh = '0;
  logic [31:0] cmd_word = '0;
  logic [7:0]  first_byte = '0;
  int          win_bits[$];
  logic [7:0]  win_first[$];
  logic [31:0] win_cmd[$];

  always @(posedge sclk or posedge scs) begin
    if (scs) begin
      if (mosi_bits > 0) begin
        win_bits.push_back(mosi_bits);
        win_first.push_back(first_byte);
        win_cmd.push_back(cmd_word);
      end
      mosi_bits = 0;
      cmd_word  = '0;
    end else begin
      mosi_sh = {mosi_sh[30:0], mosi};
      mosi_bits++;
      if (mosi_bits == 8) first_byte = mosi_sh[7:0];
      if (mosi_bits == 32) cmd_word = mosi_sh;
    end
  end

  // Flash drives data after each falling SPI clock past the command.
  always @(negedge sclk) begin
    int idx;
    logic [7:0] b;
    if (!scs && mosi_bits >= 32) begin
      idx  = mosi_bits - 32;
      b    = flash_byte(cmd_word[23:0] + 24'(idx / 8));
      miso = b[7 - (idx % 8)];
    end
  end

  // Cycle-level monitor.
  int          hi_cnt = 0;
  int          gaps[$];
  logic [15:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  int          cs_bad = 0, wide = 0, overlap = 0;
  int          clk_bad = 0, stb_bad = 0, rc_late = 0;
  int          since_rise = 0, nrise = 0;
  logic        prev_we = 1'b0, prev_rc = 1'b0, prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      hi_cnt = 0;
      nrise  = 0;
    end else begin
      if (scs) begin
        hi_cnt++;
        nrise = 0;
      end else if (hi_cnt > 0) begin
        gaps.push_back(hi_cnt);
        hi_cnt = 0;
      end
      if (sclk && !prev_sclk) begin
        if (nrise > 0 && since_rise + 1 != 2 * DIV) clk_bad++;
        nrise++;
        since_rise = 0;
      end else begin
        since_rise++;
      end
      if (we) begin
        wr_addr.push_back(raddr);
        wr_data.push_back(rdata);
        if (!rcs) cs_bad++;
        if (prev_we) wide++;
        if (rc) overlap++;
        if (since_rise != DIV) stb_bad++;
      end
      if (rc && !prev_rc && !prev_we) rc_late++;
    end
    prev_we   = we;
    prev_rc   = rc;
    prev_sclk = sclk;
  end

  // Wrap instance monitors.
  int          w_bits = 0, w_nwin = 0, w_writes = 0;
  logic [31:0] w_sh = '0;
  logic [31:0] w_cmd = '0;
  logic [7:0]  w_wake = '0;
  logic [15:0] w_last_addr = '0;
  logic [7:0]  w_last_data = '0;

  always @(posedge w_sclk or posedge w_scs) begin
    if (w_scs) begin
      if (w_bits > 0) w_nwin++;
      w_bits = 0;
    end else begin
      w_sh = {w_sh[30:0], w_mosi};
      w_bits++;
      if (w_bits == 8 && w_nwin == 0) w_wake = w_sh[7:0];
      if (w_bits == 32) w_cmd = w_sh;
    end
  end

  always @(negedge clk) begin
    if (w_we) begin
      w_writes++;
      w_last_addr = w_raddr;
      w_last_data = w_rdata;
    end
  end

  int b_win, b_gap, b_wr, b_cs, b_wide, b_ovl, b_clk, b_stb, b_rcl;

  task snap;
    b_win = win_bits.size();
    b_gap = gaps.size();
    b_wr  = wr_addr.size();
    b_cs  = cs_bad;
    b_wide = wide;
    b_ovl = overlap;
    b_clk = clk_bad;
    b_stb = stb_bad;
    b_rcl = rc_late;
  endtask

  task start_run(input logic [4:0] cfg);
    reset = 1'b1;
    @(negedge clk);
    configuration = cfg;
    snap();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task wait_done(output bit ok);
    int n;
    n = 0;
    while (rc !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    ok = (rc === 1'b1);
    @(negedge clk);
    #1;
  endtask

  task test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (scs !== 1'b1) begin
      errors++; $display("FAIL reset_spi_cs got %b exp 1", scs);
    end
    checks++;
    if (sclk !== 1'b0 || mosi !== 1'b0) begin
      errors++; $display("FAIL reset_spi got clk=%b out=%b exp 0 0", sclk, mosi);
    end
    checks++;
    if (raddr !== 16'h0 || rdata !== 8'h0) begin
      errors++; $display("FAIL reset_ram_bus got %h %h exp 0 0", raddr, rdata);
    end
    checks++;
    if (rcs !== 1'b0 || we !== 1'b0) begin
      errors++; $display("FAIL reset_ram_ctl got cs=%b we=%b exp 0 0", rcs, we);
    end
    checks++;
    if (rc !== 1'b0) begin
      errors++; $display("FAIL reset_complete got %b exp 0", rc);
    end
  endtask

  task test_image_select;
    bit ok;
    logic [31:0] exp;
    exp = 32'hDEADBEEF;
    start_run(5'b00011);
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL sel_timeout read_complete=%b exp 1", rc);
    end
    checks++;
    if (win_bits.size() - b_win != 2) begin
      errors++; $display("FAIL sel_windows got %0d exp 2", win_bits.size() - b_win);
    end else begin
      checks++;
      if (win_first[b_win] !== 8'hAB) begin
        errors++; $display("FAIL sel_wake_byte got %h exp ab", win_first[b_win]);
      end
      checks++;
      if (win_bits[b_win] != 8) begin
        errors++; $display("FAIL sel_wake_bits got %0d exp 8", win_bits[b_win]);
      end
      checks++;
      if (win_cmd[b_win+1] !== 32'h03130000) begin
        errors++; $display("FAIL sel_cmd got %h exp 03130000", win_cmd[b_win+1]);
      end
      checks++;
      if (win_bits[b_win+1] != 64) begin
        errors++; $display("FAIL sel_data_bits got %0d exp 64", win_bits[b_win+1]);
      end
    end
    checks++;
    if (gaps.size() <= b_gap || gaps[gaps.size()-1] != 200) begin
      errors++; $display("FAIL sel_wake_gap got %0d exp 200",
                         gaps.size() > 0 ? gaps[gaps.size()-1] : -1);
    end
    checks++;
    if (wr_addr.size() - b_wr != 4) begin
      errors++; $display("FAIL sel_writes got %0d exp 4", wr_addr.size() - b_wr);
    end
    for (int i = 0; i < 4; i++) begin
      if (b_wr + i < wr_addr.size()) begin
        checks++;
        if (wr_addr[b_wr+i] !== 16'(i) || wr_data[b_wr+i] !== exp[31-8*i -: 8]) begin
          errors++;
          $display("FAIL sel_write%0d got (%h,%h) exp (%h,%h)", i,
                   wr_addr[b_wr+i], wr_data[b_wr+i], 16'(i), exp[31-8*i -: 8]);
        end
      end
    end
    checks++;
    if (cs_bad != b_cs || wide != b_wide) begin
      errors++; $display("FAIL strobe_shape got cs_bad=%0d wide=%0d exp 0 0",
                         cs_bad - b_cs, wide - b_wide);
    end
    checks++;
    if (stb_bad != b_stb) begin
      errors++; $display("FAIL strobe_timing got %0d late exp 0", stb_bad - b_stb);
    end
    checks++;
    if (clk_bad != b_clk) begin
      errors++; $display("FAIL spi_clk_gap got %0d exp 0", clk_bad - b_clk);
    end
    checks++;
    if (overlap != b_ovl || rc_late != b_rcl) begin
      errors++; $display("FAIL complete_timing got ovl=%0d late=%0d exp 0 0",
                         overlap - b_ovl, rc_late - b_rcl);
    end
    checks++;
    if (raddr !== 16'd3 || scs !== 1'b1 || sclk !== 1'b0) begin
      errors++; $display("FAIL done_state got addr=%h cs=%b clk=%b exp 0003 1 0",
                         raddr, scs, sclk);
    end
  endtask

  task test_config_stability;
    int n;
    logic [31:0] exp;
    exp = 32'h5A5B5859;
    start_run(5'd1);
    n = 0;
    while (rc !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
      if (n >= 40) configuration = 5'(n * 7);
    end
    @(negedge clk);
    #1;
    checks++;
    if (rc !== 1'b1) begin
      errors++; $display("FAIL cfg_timeout read_complete=%b exp 1", rc);
    end
    checks++;
    if (win_cmd.size() < b_win + 2 || win_cmd[b_win+1] !== 32'h03110000) begin
      errors++; $display("FAIL cfg_cmd got %h exp 03110000",
                         win_cmd.size() >= b_win + 2 ? win_cmd[b_win+1] : 32'hx);
    end
    checks++;
    if (wr_addr.size() - b_wr != 4) begin
      errors++; $display("FAIL cfg_writes got %0d exp 4", wr_addr.size() - b_wr);
    end
    for (int i = 0; i < 4; i++) begin
      if (b_wr + i < wr_addr.size()) begin
        checks++;
        if (wr_addr[b_wr+i] !== 16'(i) || wr_data[b_wr+i] !== exp[31-8*i -: 8]) begin
          errors++;
          $display("FAIL cfg_write%0d got (%h,%h) exp (%h,%h)", i,
                   wr_addr[b_wr+i], wr_data[b_wr+i], 16'(i), exp[31-8*i -: 8]);
        end
      end
    end
  endtask

  task test_reset_mid;
    int n;
    bit ok;
    start_run(5'd0);
    n = 0;
    while (!(we === 1'b1 && raddr === 16'd1) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 4000) begin
      errors++; $display("FAIL mid_second_strobe got none exp strobe at 1");
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (scs !== 1'b1 || sclk !== 1'b0) begin
      errors++; $display("FAIL mid_spi got cs=%b clk=%b exp 1 0", scs, sclk);
    end
    checks++;
    if (we !== 1'b0 || rcs !== 1'b0 || raddr !== 16'h0) begin
      errors++; $display("FAIL mid_ram got we=%b cs=%b addr=%h exp 0 0 0000",
                         we, rcs, raddr);
    end
    checks++;
    if (rc !== 1'b0) begin
      errors++; $display("FAIL mid_complete got %b exp 0", rc);
    end
    @(negedge clk);
    configuration = 5'd2;
    snap();
    @(negedge clk);
    reset = 1'b0;
    wait_done(ok);
    checks++;
    if (!ok) begin
      errors++; $display("FAIL mid_timeout read_complete=%b exp 1", rc);
    end
    checks++;
    if (win_first.size() < b_win + 2 || win_first[b_win] !== 8'hAB
        || win_cmd[b_win+1] !== 32'h03120000) begin
      errors++; $display("FAIL mid_restart got wins=%0d exp AB then 03120000",
                         win_first.size() - b_win);
    end
    checks++;
    if (wr_addr.size() - b_wr != 4) begin
      errors++; $display("FAIL mid_writes got %0d exp 4", wr_addr.size() - b_wr);
    end
    for (int i = 0; i < 4; i++) begin
      if (b_wr + i < wr_addr.size()) begin
        checks++;
        if (wr_addr[b_wr+i] !== 16'(i) || wr_data[b_wr+i] !== 8'(8'h50 + i)) begin
          errors++;
          $display("FAIL mid_write%0d got (%h,%h) exp (%h,%h)", i,
                   wr_addr[b_wr+i], wr_data[b_wr+i], 16'(i), 8'(8'h50 + i));
        end
      end
    end
  endtask

  task test_wrap;
    int n;
    @(negedge clk);
    w_reset = 1'b0;
    n = 0;
    while (w_rc !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #1;
    checks++;
    if (w_rc !== 1'b1) begin
      errors++; $display("FAIL wrap_timeout read_complete=%b exp 1", w_rc);
    end
    checks++;
    if (w_wake !== 8'hAB) begin
      errors++; $display("FAIL wrap_wake_byte got %h exp ab", w_wake);
    end
    checks++;
    if (w_cmd !== 32'h03000000) begin
      errors++; $display("FAIL wrap_cmd got %h exp 03000000", w_cmd);
    end
    checks++;
    if (w_writes != 3) begin
      errors++; $display("FAIL wrap_writes got %0d exp 3", w_writes);
    end
    checks++;
    if (w_last_addr !== 16'd2 || w_last_data !== 8'hFF) begin
      errors++; $display("FAIL wrap_last got (%h,%h) exp (0002,ff)",
                         w_last_addr, w_last_data);
    end
    checks++;
    if (w_raddr !== 16'd2 || w_scs !== 1'b1) begin
      errors++; $display("FAIL wrap_done got addr=%h cs=%b exp 0002 1",
                         w_raddr, w_scs);
    end
  endtask

  initial begin
    test_reset();
    test_image_select();
    test_config_stability();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
